// File: rtl/decode_stage_if.sv
// Fetch-side and consumer-side handshake bundle for decode_stage.
// master: drives in_valid/in_code/out_ready (fetch + consumer side).
// slave:  the decode stage itself.
interface decode_stage_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_code;
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        out_op;
  logic [4:0]        out_rs;
  logic [4:0]        out_rt;
  logic [4:0]        out_rd;
  logic [4:0]        out_shamt;
  logic [5:0]        out_funct;
  logic [DATA_W-1:0] out_imm_ext;
  logic [25:0]       out_jaddr;
  logic [1:0]        out_class;
  logic              out_illegal;

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_op, out_rs, out_rt, out_rd, out_shamt, out_funct,
           out_imm_ext, out_jaddr, out_class, out_illegal
  );

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_op, out_rs, out_rt, out_rd, out_shamt, out_funct,
           out_imm_ext, out_jaddr, out_class, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Buffered MIPS-subset decode stage: combinational decode of the incoming word, then a
// DEPTH-entry FIFO of decoded results. Optional per-class push counters are enabled by
// defining DECODE_STAGE_PERF_EN.
module decode_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  decode_stage_if.slave      bus
`ifdef DECODE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]   perf_r,
  output logic [CNT_W-1:0]   perf_i,
  output logic [CNT_W-1:0]   perf_j,
  output logic [CNT_W-1:0]   perf_ill
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  if (DATA_W < 16 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : gen_bad_param
    $error("decode_stage: illegal parameter combination");
  end

  typedef enum logic [1:0] {ClsR = 2'd0, ClsI = 2'd1, ClsJ = 2'd2, ClsIll = 2'd3} cls_e;

  typedef struct packed {
    logic [5:0]        op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [DATA_W-1:0] imm;
    logic [25:0]       jaddr;
    cls_e              cls;
    logic              illegal;
  } entry_t;

  entry_t          dec;
  entry_t          head;
  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [15:0] imm16;
  assign op    = bus.in_code[31:26];
  assign funct = bus.in_code[5:0];
  assign imm16 = bus.in_code[15:0];

  // Decode the incoming word; fields outside the detected class stay zero.
  always_comb begin
    dec         = '0;
    dec.op      = op;
    dec.cls     = ClsIll;
    dec.illegal = 1'b1;
    if (op == 6'h00) begin
      if (funct inside {6'h00, 6'h02, 6'h08, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) begin
        dec.rs      = bus.in_code[25:21];
        dec.rt      = bus.in_code[20:16];
        dec.rd      = bus.in_code[15:11];
        dec.shamt   = bus.in_code[10:6];
        dec.funct   = funct;
        dec.cls     = ClsR;
        dec.illegal = 1'b0;
      end
    end else if (op inside {6'h02, 6'h03}) begin
      dec.jaddr   = bus.in_code[25:0];
      dec.cls     = ClsJ;
      dec.illegal = 1'b0;
    end else if (op inside {6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23,
                            6'h2B}) begin
      dec.rs = bus.in_code[25:21];
      dec.rt = bus.in_code[20:16];
      // Logical immediates are zero-extended, everything else sign-extended.
      if (op inside {6'h0C, 6'h0D, 6'h0E}) begin
        dec.imm = DATA_W'(imm16);
      end else begin
        dec.imm = DATA_W'(signed'(imm16));
      end
      dec.cls     = ClsI;
      dec.illegal = 1'b0;
    end
  end

  // Flush suppresses both sides of the handshake for that cycle.
  assign bus.in_ready  = (count_q < DepthCnt);
  assign bus.out_valid = (count_q != '0);
  assign do_push       = bus.in_valid && bus.in_ready && !flush;
  assign do_pop        = bus.out_valid && bus.out_ready && !flush;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; reset to zero so unwritten slots never carry X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= dec;
    end
  end

  // Head entry, forced to zero while empty.
  always_comb begin
    head = '0;
    if (bus.out_valid) head = mem_q[rd_ptr_q];
  end

  assign bus.out_op      = head.op;
  assign bus.out_rs      = head.rs;
  assign bus.out_rt      = head.rt;
  assign bus.out_rd      = head.rd;
  assign bus.out_shamt   = head.shamt;
  assign bus.out_funct   = head.funct;
  assign bus.out_imm_ext = head.imm;
  assign bus.out_jaddr   = head.jaddr;
  assign bus.out_class   = head.cls;
  assign bus.out_illegal = head.illegal;

`ifdef DECODE_STAGE_PERF_EN
  logic [CNT_W-1:0] perf_q [4];

  // Saturating per-class push counters; only rst_n clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) perf_q[i] <= '0;
    end else if (do_push && perf_q[dec.cls] != '1) begin
      perf_q[dec.cls] <= perf_q[dec.cls] + 1'b1;
    end
  end

  assign perf_r   = perf_q[ClsR];
  assign perf_i   = perf_q[ClsI];
  assign perf_j   = perf_q[ClsJ];
  assign perf_ill = perf_q[ClsIll];
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed decode cases, backpressure, flush,
// asynchronous reset and a randomized run against a queue-based reference model.
module tb_decode_stage;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] imm;
    logic [25:0] jaddr;
    logic [1:0]  cls;
    logic        ill;
  } fields_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  decode_stage_if #(.DATA_W(DW)) bus ();

`ifdef DECODE_STAGE_PERF_EN
  logic [CNT_W-1:0] perf_r, perf_i, perf_j, perf_ill;
`endif

  decode_stage #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
`ifdef DECODE_STAGE_PERF_EN
    ,
    .perf_r   (perf_r),
    .perf_i   (perf_i),
    .perf_j   (perf_j),
    .perf_ill (perf_ill)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: decoded-entry queue plus per-class push counts.
  fields_t     model_q[$];
  int unsigned m_perf [4];
  logic [5:0]  r_functs [8]  = '{6'h00, 6'h02, 6'h08, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  logic [5:0]  i_ops    [10] = '{6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                 6'h23, 6'h2B};

  function automatic bit in_r_list(logic [5:0] f);
    foreach (r_functs[k]) if (r_functs[k] == f) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit in_i_list(logic [5:0] o);
    foreach (i_ops[k]) if (i_ops[k] == o) return 1'b1;
    return 1'b0;
  endfunction

  function automatic fields_t ref_decode(logic [31:0] c);
    fields_t f = '0;
    int      imm_val;
    f.op = c[31:26];
    if (c[31:26] == 6'h00 && in_r_list(c[5:0])) begin
      f.cls = 2'd0; f.rs = c[25:21]; f.rt = c[20:16]; f.rd = c[15:11];
      f.shamt = c[10:6]; f.funct = c[5:0];
    end else if (c[31:26] == 6'h02 || c[31:26] == 6'h03) begin
      f.cls = 2'd2; f.jaddr = c[25:0];
    end else if (in_i_list(c[31:26])) begin
      f.cls = 2'd1; f.rs = c[25:21]; f.rt = c[20:16];
      imm_val = int'(c[15:0]);
      if (c[31:26] < 6'h0C || c[31:26] > 6'h0E) begin
        if (imm_val >= 32768) imm_val = imm_val - 65536;
      end
      f.imm = 32'(imm_val);
    end else begin
      f.cls = 2'd3; f.ill = 1'b1;
    end
    return f;
  endfunction

  function automatic logic [31:0] rand_code();
    logic [31:0] c = $urandom();
    case ($urandom_range(0, 4))
      0: begin c[31:26] = 6'h00; c[5:0] = r_functs[$urandom_range(0, 7)]; end
      1: c[31:26] = i_ops[$urandom_range(0, 9)];
      2: c[31:26] = 6'($urandom_range(2, 3));
      3: c[31:26] = 6'h00;
      default: ;
    endcase
    return c;
  endfunction

  function automatic fields_t observed();
    return {bus.out_op, bus.out_rs, bus.out_rt, bus.out_rd, bus.out_shamt, bus.out_funct,
            bus.out_imm_ext, bus.out_jaddr, bus.out_class, bus.out_illegal};
  endfunction

  // Advance one clock: model decides push/pop from its own occupancy, then samples at negedge.
  task automatic cycle();
    bit      push, pop;
    fields_t d;
    push = bus.in_valid && (model_q.size() < DEPTH) && !flush;
    pop  = bus.out_ready && (model_q.size() != 0) && !flush;
    d    = ref_decode(bus.in_code);
    @(posedge clk);
    if (flush) model_q.delete();
    else begin
      if (pop) void'(model_q.pop_front());
      if (push) model_q.push_back(d);
    end
    if (push && m_perf[d.cls] < (2 ** CNT_W) - 1) m_perf[d.cls]++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_hs: valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    n_checks++;
    if (observed() !== fields_t'(0)) begin
      n_errors++;
      $display("FAIL reset_fields: got %h want 0", observed());
    end
  endtask

  task automatic test_decode();
    logic [31:0] codes [5] = '{32'h012A4020, 32'h2128FFFF, 32'h3528FFFF, 32'h0C000010,
                               32'hFC000000};
    fields_t     exp   [5];
    exp[0] = '{6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 32'h0, 26'h0, 2'd0, 1'b0};
    exp[1] = '{6'h08, 5'd9, 5'd8, 5'd0, 5'd0, 6'h00, 32'hFFFFFFFF, 26'h0, 2'd1, 1'b0};
    exp[2] = '{6'h0D, 5'd9, 5'd8, 5'd0, 5'd0, 6'h00, 32'h0000FFFF, 26'h0, 2'd1, 1'b0};
    exp[3] = '{6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'h0, 26'h10, 2'd2, 1'b0};
    exp[4] = '{6'h3F, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'h0, 26'h0, 2'd3, 1'b1};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_code  = codes[i];
      cycle();
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b1 || observed() !== exp[i]) begin
        n_errors++;
        $display("FAIL decode_%0d: valid=%b got %h want %h", i, bus.out_valid, observed(),
                 exp[i]);
      end
      cycle();
      n_checks++;
      if (bus.out_valid !== 1'b0 || observed() !== fields_t'(0)) begin
        n_errors++;
        $display("FAIL popped_%0d: valid=%b fields=%h want 0", i, bus.out_valid, observed());
      end
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL fill_ready_%0d: got %b want 1", i, bus.in_ready);
      end
      bus.in_valid = 1'b1;
      bus.in_code  = rand_code();
      cycle();
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL full: ready=%b valid=%b want 0/1", bus.in_ready, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      n_checks++;
      if (model_q.size() == 0 || observed() !== model_q[0]) begin
        n_errors++;
        $display("FAIL drain_%0d: got %h want %h", i, observed(),
                 model_q.size() != 0 ? model_q[0] : fields_t'(0));
      end
      cycle();
      if (i == 0) begin
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
          n_errors++;
          $display("FAIL ready_after_pop: got %b want 1", bus.in_ready);
        end
      end
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL drained: valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      bus.in_code = rand_code();
      cycle();
    end
    flush        = 1'b1;
    bus.in_code  = 32'h012A4020;
    cycle();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || observed() !== fields_t'(0)) begin
      n_errors++;
      $display("FAIL flush: valid=%b ready=%b fields=%h want 0/1/0", bus.out_valid,
               bus.in_ready, observed());
    end
`ifdef DECODE_STAGE_PERF_EN
    n_checks++;
    if ({perf_r, perf_i, perf_j, perf_ill} !== {CNT_W'(m_perf[0]), CNT_W'(m_perf[1]),
                                                 CNT_W'(m_perf[2]), CNT_W'(m_perf[3])}) begin
      n_errors++;
      $display("FAIL perf_flush: got %h %h %h %h want %0d %0d %0d %0d", perf_r, perf_i,
               perf_j, perf_ill, m_perf[0], m_perf[1], m_perf[2], m_perf[3]);
    end
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      n_checks++;
      if (bus.out_valid !== (model_q.size() != 0) || bus.in_ready !== (model_q.size() < DEPTH))
      begin
        n_errors++;
        $display("FAIL rand_hs_%0d: valid=%b ready=%b occupancy=%0d", n, bus.out_valid,
                 bus.in_ready, model_q.size());
      end
      n_checks++;
      if (observed() !== (model_q.size() != 0 ? model_q[0] : fields_t'(0))) begin
        n_errors++;
        $display("FAIL rand_head_%0d: got %h want %h", n, observed(),
                 model_q.size() != 0 ? model_q[0] : fields_t'(0));
      end
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.in_code   = rand_code();
      flush         = ($urandom_range(0, 39) == 0);
      cycle();
    end
    flush = 1'b0;
`ifdef DECODE_STAGE_PERF_EN
    n_checks++;
    if ({perf_r, perf_i, perf_j, perf_ill} !== {CNT_W'(m_perf[0]), CNT_W'(m_perf[1]),
                                                 CNT_W'(m_perf[2]), CNT_W'(m_perf[3])}) begin
      n_errors++;
      $display("FAIL perf_rand: got %h %h %h %h want %0d %0d %0d %0d", perf_r, perf_i,
               perf_j, perf_ill, m_perf[0], m_perf[1], m_perf[2], m_perf[3]);
    end
`endif
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.in_code = rand_code();
      cycle();
    end
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_q.delete();
    foreach (m_perf[k]) m_perf[k] = 0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || observed() !== fields_t'(0)) begin
      n_errors++;
      $display("FAIL async_reset: valid=%b ready=%b fields=%h want 0/1/0", bus.out_valid,
               bus.in_ready, observed());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`ifdef DECODE_STAGE_PERF_EN
    n_checks++;
    if ({perf_r, perf_i, perf_j, perf_ill} !== '0) begin
      n_errors++;
      $display("FAIL perf_reset: got %h %h %h %h want 0", perf_r, perf_i, perf_j, perf_ill);
    end
`endif
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_code   = '0;
    bus.out_ready = 1'b0;
    foreach (m_perf[k]) m_perf[k] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_decode();
    test_backpressure();
    test_flush();
    test_random();
    test_async_reset();
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
